mem_stage_pipe: RTL and testbench
=================================

# mem_stage_pipe

Registered, handshaked memory stage for the Y86-64 pipeline. It replaces the purely combinational memory-stage decode with a block that accepts one instruction per cycle from execute, runs multi-cycle data-memory transactions with a request/acknowledge protocol and a timeout watchdog, and presents registered results to write-back. It sits between the execute pipeline register and write-back. After the first non-AOK status it stops accepting instructions until reset.

## Interface
- DATA_W, 64, data and address width in bits (multiple of 8)
- TIMEOUT, 15, max cycles to wait for dm_ack (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_icode  in  4  icode (`defines.vh` I* codes)
- in_valA / in_valE / in_valP  in  DATA_W  operands from execute
- in_imem_err  in  1  fetch address error
- in_instr_valid  in  1  0 = illegal instruction
- dm_req  out  1  memory request, held until dm_ack
- dm_we  out  1  1 = write
- dm_addr / dm_wdata  out  DATA_W  address / write data
- dm_ack  in  1  transaction complete this cycle
- dm_rdata  in  DATA_W  read data, valid with dm_ack
- dm_err  in  1  bus error, valid with dm_ack
- out_valid  out  1  result register full
- out_ready  in  1  write-back consumes
- out_icode  out  4; out_valE / out_valM  out  DATA_W; out_stat  out  2 (`SAOK/`SHLT/`SADR/`SINS)

## Operation
- Decode: read = IMRMOVQ, IPOPQ, IRET; write = IRMMOVQ, IPUSHQ, ICALL. Address = valE for IRMMOVQ, IMRMOVQ, IPUSHQ, ICALL; valA for IPOPQ, IRET. Write data = valP for ICALL, else valA.
- No memory access if in_imem_err, !in_instr_valid, or icode not read/write.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !halted.
- FSM IDLE: on accept of a memory op, latch request and go to ACCESS; on accept of any other op, load the result register directly.
- FSM ACCESS: dm_req=1 with dm_we/dm_addr/dm_wdata stable. On dm_ack, drop dm_req, load the result (valM = dm_rdata on reads, else 0), and go to IDLE. The counter increments each ACCESS cycle without ack. When the count reaches TIMEOUT, drop dm_req, complete with a data-memory error, and go to IDLE.
- Status priority: imem_err, dm_err, timeout or misalign → SADR; !instr_valid → SINS; IHALT → SHLT; else SAOK.
- The halted flag sets when a result with stat ≠ SAOK is loaded. It is cleared only by reset.
- out_valE = in_valE passthrough. out_valM = 0 for non-reads and errored reads.

## Timing
- Reset: state IDLE, halted 0, counter 0. dm_req, dm_we, dm_addr, dm_wdata, out_valid, out_icode, out_valE, out_valM = 0. out_stat = `SAOK. in_ready = 1.
- Non-memory op: out_valid the cycle after accept. Throughput 1/cycle while out_ready is held high.
- Memory op: dm_req rises the cycle after accept. out_valid rises the cycle after dm_ack. Zero-wait memory (ack in the first dm_req cycle) gives 2-cycle latency.
- Timeout: dm_req is high for exactly TIMEOUT cycles, then out_valid the next cycle.
- Output is held stable while out_valid && !out_ready. Simultaneous drain and load is allowed.
- Asserting rst_n low mid-ACCESS drops dm_req immediately and abandons the transaction. Memory must tolerate this.
- dm_ack outside ACCESS is ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined: if a memory op has dm_addr[log2(DATA_W/8)-1:0] ≠ 0, no request is issued. The result is loaded the cycle after accept with stat SADR.
- Undefined: no alignment check. Unaligned addresses go to memory unchanged.

## Test plan
- Reset, then IOPQ with valE=0x10 and out_ready=1 → out_valid next cycle, out_valE=0x10, out_stat=SAOK, dm_req never asserted.
- IMRMOVQ valE=0x40, dm_ack after 3 wait cycles with rdata=0xDEADBEEF → dm_req high 4 cycles at addr 0x40 with dm_we=0. out_valM=0xDEADBEEF one cycle after ack. in_ready low throughout.
- ICALL valE=0x1F8, valP=0x123, immediate ack → dm_we=1, dm_addr=0x1F8, dm_wdata=0x123.
- IPOPQ valA=0x200, no ack, TIMEOUT=15 → dm_req drops after 15 cycles. out_stat=SADR. in_ready stays 0 afterwards until rst_n pulses.
- IHALT followed by an IOPQ → out_stat=SHLT, and the IOPQ is never accepted. With in_instr_valid=0 on IRMMOVQ → SINS, no dm_req.
- With MEM_ALIGN_CHECK_EN, IRMMOVQ valE=0x41 → no dm_req, out_stat=SADR one cycle after accept. Without the macro, dm_addr=0x41 is issued.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// Registered, handshaked Y86-64 memory stage: one instruction per cycle from execute,
// multi-cycle data-memory access with timeout. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage_pipe #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [DATA_W-1:0] in_valA,
    input  logic [DATA_W-1:0] in_valE,
    input  logic [DATA_W-1:0] in_valP,
    input  logic              in_imem_err,
    input  logic              in_instr_valid,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [DATA_W-1:0] out_valE,
    output logic [DATA_W-1:0] out_valM,
    output logic [1:0]        out_stat,
    output logic              dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and the producer holds its payload stable until transfer.
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [1:0] SAOK = 2'd0;
    localparam logic [1:0] SHLT = 2'd1;
    localparam logic [1:0] SADR = 2'd2;
    localparam logic [1:0] SINS = 2'd3;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               halted_q;
    logic [3:0]         lat_icode;
    logic [DATA_W-1:0]  lat_valE;
    logic               lat_rd;

    logic               is_rd, is_wr, mem_op, misalign, start_req, load;
    logic [DATA_W-1:0]  req_addr, req_wdata;
    logic [3:0]         res_icode;
    logic [DATA_W-1:0]  res_valE, res_valM;
    logic [1:0]         res_stat;

    assign in_ready  = (state_q == IDLE) && (!out_valid || out_ready) && !halted_q;
    assign dm_req    = (state_q == ACCESS);
    assign dbg_state = state_q;

    always_comb begin
        is_rd     = (in_icode == IMRMOVQ) || (in_icode == IPOPQ) || (in_icode == IRET);
        is_wr     = (in_icode == IRMMOVQ) || (in_icode == IPUSHQ) || (in_icode == ICALL);
        mem_op    = (is_rd || is_wr) && !in_imem_err && in_instr_valid;
        req_addr  = ((in_icode == IPOPQ) || (in_icode == IRET)) ? in_valA : in_valE;
        req_wdata = (in_icode == ICALL) ? in_valP : in_valA;
`ifdef MEM_ALIGN_CHECK_EN
        misalign  = mem_op && ((req_addr & DATA_W'((DATA_W / 8) - 1)) != '0);
`else
        misalign  = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        start_req = 1'b0;
        load      = 1'b0;
        res_icode = in_icode;
        res_valE  = in_valE;
        res_valM  = '0;
        res_stat  = SAOK;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (mem_op && !misalign) begin
                        start_req = 1'b1;
                        state_d   = ACCESS;
                    end else begin
                        load = 1'b1;
                        if (in_imem_err || misalign) res_stat = SADR;
                        else if (!in_instr_valid)    res_stat = SINS;
                        else if (in_icode == IHALT)  res_stat = SHLT;
                        else                         res_stat = SAOK;
                    end
                end
            end
            ACCESS: begin
                res_icode = lat_icode;
                res_valE  = lat_valE;
                // An ack on the final allowed cycle still wins over the timeout.
                if (dm_ack) begin
                    load     = 1'b1;
                    res_stat = dm_err ? SADR : SAOK;
                    res_valM = (lat_rd && !dm_err) ? dm_rdata : '0;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    load     = 1'b1;
                    res_stat = SADR;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            lat_icode <= '0;
            lat_valE  <= '0;
            lat_rd    <= 1'b0;
            out_valid <= 1'b0;
            out_icode <= '0;
            out_valE  <= '0;
            out_valM  <= '0;
            out_stat  <= SAOK;
        end else begin
            if (start_req) begin
                dm_we     <= is_wr;
                dm_addr   <= req_addr;
                dm_wdata  <= req_wdata;
                lat_icode <= in_icode;
                lat_valE  <= in_valE;
                lat_rd    <= is_rd;
            end
            if ((state_q == ACCESS) && (state_d == ACCESS)) cnt_q <= cnt_q + 1'b1;
            else                                            cnt_q <= '0;
            if (load) begin
                out_valid <= 1'b1;
                out_icode <= res_icode;
                out_valE  <= res_valE;
                out_valM  <= res_valM;
                out_stat  <= res_stat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load && (res_stat != SAOK)) halted_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed vector table, hand sequences for stalls/reset,
// and randomized instructions checked against a rule-level reference model.
module tb_mem_stage_pipe;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 99;

    localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRMMOVQ = 4'h4, IMRMOVQ = 4'h5,
                           IOPQ = 4'h6, ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
    localparam logic [1:0] SAOK = 2'd0, SHLT = 2'd1, SADR = 2'd2, SINS = 2'd3;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] val_a, val_e, val_p;
        logic        imem_err, instr_valid;
        int          ack_delay;
        logic [63:0] rdata;
        logic        err;
        logic [1:0]  exp_stat;
        logic [63:0] exp_val_m;
        int          exp_req;
        logic        exp_we;
        logic [63:0] exp_addr, exp_wdata;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic [3:0] in_icode = '0;
    logic [DATA_W-1:0] in_valA = '0, in_valE = '0, in_valP = '0;
    logic in_imem_err = 1'b0, in_instr_valid = 1'b1;
    logic dm_req, dm_we;
    logic [DATA_W-1:0] dm_addr, dm_wdata;
    logic dm_ack = 1'b0, dm_err = 1'b0;
    logic [DATA_W-1:0] dm_rdata = '0;
    logic out_valid, out_ready = 1'b1;
    logic [3:0] out_icode;
    logic [DATA_W-1:0] out_valE, out_valM;
    logic [1:0] out_stat;
    logic dbg_state;

    int n_vec = 0, n_err = 0;
    logic [DATA_W-1:0] exp_q[$];

    mem_stage_pipe #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_valA(in_valA), .in_valE(in_valE), .in_valP(in_valP),
        .in_imem_err(in_imem_err), .in_instr_valid(in_instr_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
        .out_valE(out_valE), .out_valM(out_valM), .out_stat(out_stat), .dbg_state(dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; dm_ack = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_dm_req", dm_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_stat", out_stat, SAOK);
        check("rst_in_ready", in_ready, 1);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_out_valE", out_valE, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] ic, input logic [63:0] a, e, p,
                                input logic ime, iv, input int dly, input logic [63:0] rd,
                                input logic er, input logic [1:0] st, input logic [63:0] vm,
                                input int req, input logic we, input logic [63:0] ad, wd);
        vec_t v;
        v.icode = ic; v.val_a = a; v.val_e = e; v.val_p = p; v.imem_err = ime;
        v.instr_valid = iv; v.ack_delay = dly; v.rdata = rd; v.err = er;
        v.exp_stat = st; v.exp_val_m = vm; v.exp_req = req; v.exp_we = we;
        v.exp_addr = ad; v.exp_wdata = wd;
        return v;
    endfunction

    // Reference model: expected outcome from the decode and status rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit rd, wr, mem, mis;
        rd = (v.icode == IMRMOVQ) || (v.icode == IPOPQ) || (v.icode == IRET);
        wr = (v.icode == IRMMOVQ) || (v.icode == IPUSHQ) || (v.icode == ICALL);
        mem = (rd || wr) && !v.imem_err && v.instr_valid;
        r.exp_addr  = ((v.icode == IPOPQ) || (v.icode == IRET)) ? v.val_a : v.val_e;
        r.exp_wdata = (v.icode == ICALL) ? v.val_p : v.val_a;
        r.exp_we    = wr;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = mem && (r.exp_addr % 8 != 0);
`endif
        r.exp_val_m = 0;
        if (!mem || mis) begin
            r.exp_req = 0;
            if (v.imem_err || mis)   r.exp_stat = SADR;
            else if (!v.instr_valid) r.exp_stat = SINS;
            else if (v.icode == IHALT) r.exp_stat = SHLT;
            else                     r.exp_stat = SAOK;
        end else if (v.ack_delay < TIMEOUT) begin
            r.exp_req   = v.ack_delay + 1;
            r.exp_stat  = v.err ? SADR : SAOK;
            r.exp_val_m = (rd && !v.err) ? v.rdata : 64'd0;
        end else begin
            r.exp_req  = TIMEOUT;
            r.exp_stat = SADR;
        end
        return r;
    endfunction

    // Driver: present one instruction, act as memory, then check the result.
    task automatic apply(input vec_t v);
        int req_cycles = 0;
        bit got = 0;
        @(negedge clk);
        in_valid = 1'b1; in_icode = v.icode; in_valA = v.val_a; in_valE = v.val_e;
        in_valP = v.val_p; in_imem_err = v.imem_err; in_instr_valid = v.instr_valid;
        check("in_ready_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < TIMEOUT + 5; c++) begin
            if (out_valid) begin got = 1; break; end
            if (dm_req) begin
                check("dm_we", dm_we, v.exp_we);
                check("dm_addr", dm_addr, v.exp_addr);
                check("dm_wdata", dm_wdata, v.exp_wdata);
                check("in_ready_busy", in_ready, 0);
                if (req_cycles == v.ack_delay) begin
                    dm_ack = 1'b1; dm_rdata = v.rdata; dm_err = v.err;
                end else begin
                    dm_ack = 1'b0; dm_rdata = {$urandom, $urandom}; dm_err = 1'b0;
                end
                req_cycles++;
            end else begin
                dm_ack = 1'b0;
            end
            @(negedge clk);
        end
        dm_ack = 1'b0; dm_err = 1'b0;
        check("out_valid", got, 1);
        if (got) begin
            check("out_icode", out_icode, v.icode);
            check("out_valE", out_valE, v.val_e);
            check("out_valM", out_valM, v.exp_val_m);
            check("out_stat", out_stat, v.exp_stat);
            check("req_cycles", req_cycles, v.exp_req);
            check("dm_req_after", dm_req, 0);
            check("in_ready_done", in_ready, v.exp_stat == SAOK);
        end
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(IOPQ, 0, 64'h10, 0, 0, 1, 0, 0, 0, SAOK, 0, 0, 0, 0, 0);
        tbl[1]  = mk(IMRMOVQ, 64'h7, 64'h40, 0, 0, 1, 3, 64'hDEADBEEF, 0, SAOK, 64'hDEADBEEF, 4, 0, 64'h40, 64'h7);
        tbl[2]  = mk(ICALL, 64'h999, 64'h1F8, 64'h123, 0, 1, 0, 64'h55, 0, SAOK, 0, 1, 1, 64'h1F8, 64'h123);
        tbl[3]  = mk(IPOPQ, 64'h200, 64'h208, 0, 0, 1, NEVER, 0, 0, SADR, 0, 15, 0, 64'h200, 64'h200);
        tbl[4]  = mk(IHALT, 0, 0, 0, 0, 1, 0, 0, 0, SHLT, 0, 0, 0, 0, 0);
        tbl[5]  = mk(IRMMOVQ, 64'h1, 64'h48, 0, 0, 0, 0, 0, 0, SINS, 0, 0, 0, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        tbl[6]  = mk(IRMMOVQ, 64'hAB, 64'h41, 0, 0, 1, 0, 0, 0, SADR, 0, 0, 1, 64'h41, 64'hAB);
`else
        tbl[6]  = mk(IRMMOVQ, 64'hAB, 64'h41, 0, 0, 1, 0, 0, 0, SAOK, 0, 1, 1, 64'h41, 64'hAB);
`endif
        tbl[7]  = mk(IRET, 64'h300, 64'h308, 0, 0, 1, 1, 64'h777, 1, SADR, 0, 2, 0, 64'h300, 64'h300);
        tbl[8]  = mk(IPUSHQ, 64'h5, 64'h100, 0, 1, 1, 0, 0, 0, SADR, 0, 0, 1, 64'h100, 64'h5);
        tbl[9]  = mk(IMRMOVQ, 64'h3, 64'h88, 0, 0, 1, 14, 64'h1234, 0, SAOK, 64'h1234, 15, 0, 64'h88, 64'h3);
        tbl[10] = mk(INOP, 0, 64'hABC, 0, 0, 1, 0, 0, 0, SAOK, 0, 0, 0, 0, 0);

        // Directed table; a faulted status must keep the stage closed.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            apply(tbl[i]);
            if (tbl[i].exp_stat != SAOK) begin
                repeat (2) begin
                    @(negedge clk);
                    check("halted_in_ready", in_ready, 0);
                end
            end
        end

        // IHALT then IOPQ: the IOPQ is never accepted.
        do_reset();
        apply(tbl[4]);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_icode = IOPQ; in_valE = 64'h99; in_imem_err = 1'b0; in_instr_valid = 1'b1;
            check("halt_block_ready", in_ready, 0);
        end
        check("halt_block_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;

        // Back-to-back throughput with the scoreboard queue.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                check("b2b_valid", out_valid, 1);
                check("b2b_valE", out_valE, exp_q.pop_front());
            end
            if (i < 5) begin
                in_valid = 1'b1; in_icode = IOPQ; in_valE = 64'(i * 8 + 3);
                check("b2b_ready", in_ready, 1);
                exp_q.push_back(64'(i * 8 + 3));
            end else begin
                in_valid = 1'b0;
            end
        end

        // Backpressure: output held, then simultaneous drain and load.
        do_reset();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_icode = IOPQ; in_valE = 64'h55;
        @(negedge clk);
        in_valE = 64'h66;
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", out_valid, 1);
            check("bp_valE_hold", out_valE, 64'h55);
            check("bp_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_reload_valid", out_valid, 1);
        check("bp_reload_valE", out_valE, 64'h66);

        // Reset in the middle of an access abandons it at once.
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_icode = IMRMOVQ; in_valE = 64'h80; in_instr_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_req_before", dm_req, 1);
        rst_n = 1'b0;
        #1;
        check("mid_req_dropped", dm_req, 0);
        check("mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        // A stray ack while idle must not disturb the next instruction.
        dm_ack = 1'b1; dm_rdata = 64'hFFFF;
        apply(tbl[0]);

        // Randomized instructions against the reference model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            vec_t v;
            int r;
            v.icode = 4'($urandom_range(0, 15));
            v.val_a = {$urandom, $urandom}; v.val_e = {$urandom, $urandom}; v.val_p = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) begin
                v.val_a = v.val_a & ~64'h7; v.val_e = v.val_e & ~64'h7;
            end
            v.imem_err = ($urandom_range(0, 15) == 0);
            v.instr_valid = ($urandom_range(0, 15) != 0);
            r = $urandom_range(0, 19);
            v.ack_delay = (r == 0) ? NEVER : r % 5;
            v.rdata = {$urandom, $urandom};
            v.err = ($urandom_range(0, 9) == 0);
            v = model(v);
            apply(v);
            if (v.exp_stat != SAOK) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
